decode_stage: RTL and testbench

- Registered instruction-decode pipeline stage for the pipelined CPU: it decodes a fetched instruction into control signals and holds them in a one-entry ID/EX output register.
- Extends the combinational decode with:
  - a configurable extended-op set (slt, lui, jal, jr);
  - resolved destination-register addressing;
  - load-use hazard detection with bubble insertion;
  - valid/ready handshake with flush;
  - performance counters.
- Sits between the fetch stage (IF/ID) and the execute stage.

---
 rtl/decode_stage.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Registered instruction-decode stage: decodes a fetched MIPS-style word into execute
// controls, detects load-use hazards, and holds the result in a one-entry ID/EX register.
module decode_stage #(
    parameter int PC_W    = 32,
    parameter int RA_W    = 5,
    parameter int EXT_OPS = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [PC_W-1:0]  pc,
    input  logic             flush,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [3:0]       out_aluOp,
    output logic             out_aluSrcA,
    output logic             out_aluSrcB,
    output logic             out_rfWE,
    output logic [RA_W-1:0]  out_rfDst,
    output logic [1:0]       out_rfSrc,
    output logic             out_memWE,
    output logic             out_memRE,
    output logic [2:0]       out_branch,
    output logic [RA_W-1:0]  out_rs,
    output logic [RA_W-1:0]  out_rt,
    output logic [31:0]      out_imm,
    output logic [PC_W-1:0]  out_pc,
    output logic             out_illegal,
    output logic [CNT_W-1:0] cnt_issued,
    output logic [CNT_W-1:0] cnt_bubbles,
    output logic [CNT_W-1:0] cnt_illegal
);

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLL = 4'd4;
    localparam logic [3:0] ALU_SRL = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_LUI = 4'd7;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_J    = 3'd3;
    localparam logic [2:0] BR_JAL  = 3'd4;
    localparam logic [2:0] BR_JR   = 3'd5;

    localparam logic [1:0] RFS_ALU = 2'd0;
    localparam logic [1:0] RFS_MEM = 2'd1;
    localparam logic [1:0] RFS_PC4 = 2'd2;

    logic [5:0]      opcode, funct;
    logic [RA_W-1:0] rsF, rtF, rdF;

    assign opcode = inst[31:26];
    assign funct  = inst[5:0];
    assign rsF    = RA_W'(inst[25:21]);
    assign rtF    = RA_W'(inst[20:16]);
    assign rdF    = RA_W'(inst[15:11]);

    logic [3:0]      decAluOp;
    logic            decSrcA, decSrcB, decRfWE, decMemWE, decMemRE, decIllegal;
    logic            usesRs, usesRt;
    logic [RA_W-1:0] decDst;
    logic [1:0]      decRfSrc;
    logic [2:0]      decBranch;
    logic [31:0]     decImm;

    always_comb begin
        decAluOp   = ALU_ADD;
        decSrcA    = 1'b0;
        decSrcB    = 1'b0;
        decRfWE    = 1'b0;
        decDst     = rdF;
        decRfSrc   = RFS_ALU;
        decMemWE   = 1'b0;
        decMemRE   = 1'b0;
        decBranch  = BR_NONE;
        decImm     = {{16{inst[15]}}, inst[15:0]};
        decIllegal = 1'b0;
        usesRs     = 1'b0;
        usesRt     = 1'b0;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b000000: begin decAluOp = ALU_SLL; decSrcA = 1'b1; decRfWE = 1'b1; usesRt = 1'b1; end
                    6'b000010: begin decAluOp = ALU_SRL; decSrcA = 1'b1; decRfWE = 1'b1; usesRt = 1'b1; end
                    6'b100000: begin decAluOp = ALU_ADD; decRfWE = 1'b1; usesRs = 1'b1; usesRt = 1'b1; end
                    6'b100010: begin decAluOp = ALU_SUB; decRfWE = 1'b1; usesRs = 1'b1; usesRt = 1'b1; end
                    6'b100100: begin decAluOp = ALU_AND; decRfWE = 1'b1; usesRs = 1'b1; usesRt = 1'b1; end
                    6'b100101: begin decAluOp = ALU_OR;  decRfWE = 1'b1; usesRs = 1'b1; usesRt = 1'b1; end
                    6'b101010: begin
                        if (EXT_OPS != 0) begin
                            decAluOp = ALU_SLT; decRfWE = 1'b1; usesRs = 1'b1; usesRt = 1'b1;
                        end else begin
                            decIllegal = 1'b1;
                        end
                    end
                    6'b001000: begin
                        if (EXT_OPS != 0) begin
                            decBranch = BR_JR; usesRs = 1'b1;
                        end else begin
                            decIllegal = 1'b1;
                        end
                    end
                    default: decIllegal = 1'b1;
                endcase
            end
            6'b000010: begin decBranch = BR_J; decImm = {6'b0, inst[25:0]}; end
            6'b000011: begin
                if (EXT_OPS != 0) begin
                    decBranch = BR_JAL; decRfWE = 1'b1; decDst = RA_W'(31);
                    decRfSrc  = RFS_PC4; decImm = {6'b0, inst[25:0]};
                end else begin
                    decIllegal = 1'b1;
                end
            end
            6'b000100: begin decBranch = BR_BEQ; decAluOp = ALU_SUB; usesRs = 1'b1; usesRt = 1'b1; end
            6'b000101: begin decBranch = BR_BNE; decAluOp = ALU_SUB; usesRs = 1'b1; usesRt = 1'b1; end
            6'b001000: begin decSrcB = 1'b1; decRfWE = 1'b1; decDst = rtF; usesRs = 1'b1; end
            6'b001100: begin
                decAluOp = ALU_AND; decSrcB = 1'b1; decRfWE = 1'b1; decDst = rtF;
                decImm   = {16'b0, inst[15:0]}; usesRs = 1'b1;
            end
            6'b001101: begin
                decAluOp = ALU_OR; decSrcB = 1'b1; decRfWE = 1'b1; decDst = rtF;
                decImm   = {16'b0, inst[15:0]}; usesRs = 1'b1;
            end
            6'b100011: begin
                decSrcB  = 1'b1; decRfWE = 1'b1; decDst = rtF; decRfSrc = RFS_MEM;
                decMemRE = 1'b1; usesRs = 1'b1;
            end
            6'b101011: begin decSrcB = 1'b1; decMemWE = 1'b1; usesRs = 1'b1; usesRt = 1'b1; end
            6'b001111: begin
                if (EXT_OPS != 0) begin
                    decAluOp = ALU_LUI; decSrcB = 1'b1; decRfWE = 1'b1; decDst = rtF;
                    decImm   = {inst[15:0], 16'b0};
                end else begin
                    decIllegal = 1'b1;
                end
            end
            default: decIllegal = 1'b1;
        endcase
        // Register 0 is hard zero, so a write there is dropped at decode.
        if (decDst == '0) decRfWE = 1'b0;
    end

    logic            valid_q, valid_d;
    logic [3:0]      aluOp_q, aluOp_d;
    logic            srcA_q, srcA_d, srcB_q, srcB_d;
    logic            rfWE_q, rfWE_d, memWE_q, memWE_d, memRE_q, memRE_d;
    logic            illegal_q, illegal_d;
    logic [RA_W-1:0] rfDst_q, rfDst_d, rs_q, rs_d, rt_q, rt_d;
    logic [1:0]      rfSrc_q, rfSrc_d;
    logic [2:0]      branch_q, branch_d;
    logic [31:0]     imm_q, imm_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0] issued_q, issued_d, bubbles_q, bubbles_d, illCnt_q, illCnt_d;

    logic haz, accept;

    // A load still in the output register cannot forward in time to a dependent follower.
    assign haz = in_valid && valid_q && memRE_q && (rfDst_q != '0) &&
                 ((usesRs && (rsF == rfDst_q)) || (usesRt && (rtF == rfDst_q)));
    assign in_ready = !flush && !haz && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        valid_d   = valid_q;
        aluOp_d   = aluOp_q;
        srcA_d    = srcA_q;
        srcB_d    = srcB_q;
        rfWE_d    = rfWE_q;
        rfDst_d   = rfDst_q;
        rfSrc_d   = rfSrc_q;
        memWE_d   = memWE_q;
        memRE_d   = memRE_q;
        branch_d  = branch_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        imm_d     = imm_q;
        pc_d      = pc_q;
        illegal_d = illegal_q;
        issued_d  = issued_q;
        bubbles_d = bubbles_q;
        illCnt_d  = illCnt_q;
        if (!flush && valid_q && !out_ready) begin
            valid_d = valid_q;
        end else if (!flush && accept) begin
            valid_d   = 1'b1;
            aluOp_d   = decAluOp;
            srcA_d    = decSrcA;
            srcB_d    = decSrcB;
            rfWE_d    = decRfWE;
            rfDst_d   = decDst;
            rfSrc_d   = decRfSrc;
            memWE_d   = decMemWE;
            memRE_d   = decMemRE;
            branch_d  = decBranch;
            rs_d      = rsF;
            rt_d      = rtF;
            imm_d     = decImm;
            pc_d      = pc;
            illegal_d = decIllegal;
            issued_d  = satInc(issued_q);
            if (decIllegal) illCnt_d = satInc(illCnt_q);
        end else begin
            // Flush, bubble or drain: the slot empties and its enables go quiet.
            valid_d   = 1'b0;
            rfWE_d    = 1'b0;
            memWE_d   = 1'b0;
            memRE_d   = 1'b0;
            branch_d  = BR_NONE;
            illegal_d = 1'b0;
            if (!flush && haz) bubbles_d = satInc(bubbles_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            aluOp_q   <= ALU_ADD;
            srcA_q    <= 1'b0;
            srcB_q    <= 1'b0;
            rfWE_q    <= 1'b0;
            rfDst_q   <= '0;
            rfSrc_q   <= RFS_ALU;
            memWE_q   <= 1'b0;
            memRE_q   <= 1'b0;
            branch_q  <= BR_NONE;
            rs_q      <= '0;
            rt_q      <= '0;
            imm_q     <= '0;
            pc_q      <= '0;
            illegal_q <= 1'b0;
            issued_q  <= '0;
            bubbles_q <= '0;
            illCnt_q  <= '0;
        end else begin
            valid_q   <= valid_d;
            aluOp_q   <= aluOp_d;
            srcA_q    <= srcA_d;
            srcB_q    <= srcB_d;
            rfWE_q    <= rfWE_d;
            rfDst_q   <= rfDst_d;
            rfSrc_q   <= rfSrc_d;
            memWE_q   <= memWE_d;
            memRE_q   <= memRE_d;
            branch_q  <= branch_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            imm_q     <= imm_d;
            pc_q      <= pc_d;
            illegal_q <= illegal_d;
            issued_q  <= issued_d;
            bubbles_q <= bubbles_d;
            illCnt_q  <= illCnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_aluOp   = aluOp_q;
    assign out_aluSrcA = srcA_q;
    assign out_aluSrcB = srcB_q;
    assign out_rfWE    = rfWE_q;
    assign out_rfDst   = rfDst_q;
    assign out_rfSrc   = rfSrc_q;
    assign out_memWE   = memWE_q;
    assign out_memRE   = memRE_q;
    assign out_branch  = branch_q;
    assign out_rs      = rs_q;
    assign out_rt      = rt_q;
    assign out_imm     = imm_q;
    assign out_pc      = pc_q;
    assign out_illegal = illegal_q;
    assign cnt_issued  = issued_q;
    assign cnt_bubbles = bubbles_q;
    assign cnt_illegal = illCnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a default instance, an EXT_OPS=0 instance and a
// CNT_W=2 instance share one input stream; expected values are hand-computed constants.
module tb_decode_stage;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_LUI = 4'd7;
    localparam logic [2:0] BR_JAL  = 3'd4;
    localparam logic [1:0] RFS_MEM = 2'd1;
    localparam logic [1:0] RFS_PC4 = 2'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, flush, out_ready;
    logic [31:0] inst, pc;

    logic        a_inRdy, a_valid, a_srcA, a_srcB, a_rfWE, a_memWE, a_memRE, a_ill;
    logic [3:0]  a_aluOp;
    logic [4:0]  a_dst, a_rs, a_rt;
    logic [1:0]  a_rfSrc;
    logic [2:0]  a_br;
    logic [31:0] a_imm, a_pc;
    logic [15:0] a_cIss, a_cBub, a_cIll;

    logic        z_inRdy, z_valid, z_srcA, z_srcB, z_rfWE, z_memWE, z_memRE, z_ill;
    logic [3:0]  z_aluOp;
    logic [4:0]  z_dst, z_rs, z_rt;
    logic [1:0]  z_rfSrc;
    logic [2:0]  z_br;
    logic [31:0] z_imm, z_pc;
    logic [15:0] z_cIss, z_cBub, z_cIll;

    logic        c_inRdy, c_valid, c_srcA, c_srcB, c_rfWE, c_memWE, c_memRE, c_ill;
    logic [3:0]  c_aluOp;
    logic [4:0]  c_dst, c_rs, c_rt;
    logic [1:0]  c_rfSrc;
    logic [2:0]  c_br;
    logic [31:0] c_imm, c_pc;
    logic [1:0]  c_cIss, c_cBub, c_cIll;

    int compareCount  = 0;
    int mismatchCount = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_inRdy), .inst(inst), .pc(pc),
        .flush(flush), .out_ready(out_ready), .out_valid(a_valid), .out_aluOp(a_aluOp),
        .out_aluSrcA(a_srcA), .out_aluSrcB(a_srcB), .out_rfWE(a_rfWE), .out_rfDst(a_dst),
        .out_rfSrc(a_rfSrc), .out_memWE(a_memWE), .out_memRE(a_memRE), .out_branch(a_br),
        .out_rs(a_rs), .out_rt(a_rt), .out_imm(a_imm), .out_pc(a_pc), .out_illegal(a_ill),
        .cnt_issued(a_cIss), .cnt_bubbles(a_cBub), .cnt_illegal(a_cIll)
    );

    decode_stage #(.EXT_OPS(0)) dutNoExt (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(z_inRdy), .inst(inst), .pc(pc),
        .flush(flush), .out_ready(out_ready), .out_valid(z_valid), .out_aluOp(z_aluOp),
        .out_aluSrcA(z_srcA), .out_aluSrcB(z_srcB), .out_rfWE(z_rfWE), .out_rfDst(z_dst),
        .out_rfSrc(z_rfSrc), .out_memWE(z_memWE), .out_memRE(z_memRE), .out_branch(z_br),
        .out_rs(z_rs), .out_rt(z_rt), .out_imm(z_imm), .out_pc(z_pc), .out_illegal(z_ill),
        .cnt_issued(z_cIss), .cnt_bubbles(z_cBub), .cnt_illegal(z_cIll)
    );

    decode_stage #(.CNT_W(2)) dutSmallCnt (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_inRdy), .inst(inst), .pc(pc),
        .flush(flush), .out_ready(out_ready), .out_valid(c_valid), .out_aluOp(c_aluOp),
        .out_aluSrcA(c_srcA), .out_aluSrcB(c_srcB), .out_rfWE(c_rfWE), .out_rfDst(c_dst),
        .out_rfSrc(c_rfSrc), .out_memWE(c_memWE), .out_memRE(c_memRE), .out_branch(c_br),
        .out_rs(c_rs), .out_rt(c_rt), .out_imm(c_imm), .out_pc(c_pc), .out_illegal(c_ill),
        .cnt_issued(c_cIss), .cnt_bubbles(c_cBub), .cnt_illegal(c_cIll)
    );

    // Drive one set of inputs shortly after a rising edge and let combinational outputs settle.
    task automatic applyStimulus(input logic v, input logic [31:0] i, input logic [31:0] p,
                                 input logic ordy, input logic fl);
        in_valid  = v;
        inst      = i;
        pc        = p;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            mismatchCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out_valid", 32'(a_valid), 32'd0);
        checkOutput("reset rfWE", 32'(a_rfWE), 32'd0);
        checkOutput("reset memRE", 32'(a_memRE), 32'd0);
        checkOutput("reset cnt_issued", 32'(a_cIss), 32'd0);
        checkOutput("reset out_pc", a_pc, 32'd0);
        rst = 1'b0;

        applyStimulus(1'b1, 32'h00221820, 32'h00, 1'b1, 1'b0);
        checkOutput("add in_ready", 32'(a_inRdy), 32'd1);
        tick();
        checkOutput("add out_valid", 32'(a_valid), 32'd1);
        checkOutput("add rfDst", 32'(a_dst), 32'd3);
        checkOutput("add rfWE", 32'(a_rfWE), 32'd1);
        checkOutput("add aluOp", 32'(a_aluOp), 32'(ALU_ADD));
        checkOutput("add cnt_issued", 32'(a_cIss), 32'd1);

        applyStimulus(1'b1, 32'h8C240008, 32'h04, 1'b1, 1'b0);
        tick();
        checkOutput("lw memRE", 32'(a_memRE), 32'd1);
        checkOutput("lw rfDst", 32'(a_dst), 32'd4);
        checkOutput("lw rfSrc", 32'(a_rfSrc), 32'(RFS_MEM));
        checkOutput("lw imm", a_imm, 32'd8);

        applyStimulus(1'b1, 32'h00822820, 32'h08, 1'b1, 1'b0);
        checkOutput("loaduse in_ready", 32'(a_inRdy), 32'd0);
        tick();
        checkOutput("bubble out_valid", 32'(a_valid), 32'd0);
        checkOutput("bubble cnt_bubbles", 32'(a_cBub), 32'd1);
        checkOutput("bubble cnt_issued", 32'(a_cIss), 32'd2);
        applyStimulus(1'b1, 32'h00822820, 32'h08, 1'b1, 1'b0);
        checkOutput("after bubble in_ready", 32'(a_inRdy), 32'd1);
        tick();
        checkOutput("dependent add valid", 32'(a_valid), 32'd1);
        checkOutput("dependent add rfDst", 32'(a_dst), 32'd5);
        checkOutput("dependent add rs", 32'(a_rs), 32'd4);
        checkOutput("dependent add pc", a_pc, 32'h08);

        applyStimulus(1'b1, 32'h8C240008, 32'h0C, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h00C22820, 32'h10, 1'b1, 1'b0);
        checkOutput("independent in_ready", 32'(a_inRdy), 32'd1);
        tick();
        checkOutput("independent valid", 32'(a_valid), 32'd1);
        checkOutput("independent rs", 32'(a_rs), 32'd6);
        checkOutput("independent cnt_bubbles", 32'(a_cBub), 32'd1);
        checkOutput("cnt_issued after 5", 32'(a_cIss), 32'd5);
        checkOutput("CNT_W=2 saturates", 32'(c_cIss), 32'd3);

        applyStimulus(1'b1, 32'h2002FFFF, 32'h14, 1'b1, 1'b0);
        tick();
        checkOutput("addi imm", a_imm, 32'hFFFFFFFF);
        checkOutput("addi srcB", 32'(a_srcB), 32'd1);
        checkOutput("addi rfDst", 32'(a_dst), 32'd2);

        applyStimulus(1'b1, 32'h3402FFFF, 32'h18, 1'b1, 1'b0);
        tick();
        checkOutput("ori imm", a_imm, 32'h0000FFFF);
        checkOutput("ori aluOp", 32'(a_aluOp), 32'(ALU_OR));

        applyStimulus(1'b1, 32'h3C02FFFF, 32'h1C, 1'b1, 1'b0);
        tick();
        checkOutput("lui imm", a_imm, 32'hFFFF0000);
        checkOutput("lui aluOp", 32'(a_aluOp), 32'(ALU_LUI));
        checkOutput("lui illegal", 32'(a_ill), 32'd0);
        checkOutput("lui noext illegal", 32'(z_ill), 32'd1);
        checkOutput("lui noext rfWE", 32'(z_rfWE), 32'd0);
        checkOutput("lui noext cnt_illegal", 32'(z_cIll), 32'd1);
        checkOutput("lui ext cnt_illegal", 32'(a_cIll), 32'd0);

        applyStimulus(1'b1, 32'h0C000040, 32'h100, 1'b1, 1'b0);
        tick();
        checkOutput("jal rfDst", 32'(a_dst), 32'd31);
        checkOutput("jal branch", 32'(a_br), 32'(BR_JAL));
        checkOutput("jal rfSrc", 32'(a_rfSrc), 32'(RFS_PC4));
        checkOutput("jal rfWE", 32'(a_rfWE), 32'd1);
        checkOutput("jal pc", a_pc, 32'h100);
        checkOutput("jal noext cnt_illegal", 32'(z_cIll), 32'd2);

        applyStimulus(1'b1, 32'h00220020, 32'h104, 1'b1, 1'b0);
        tick();
        checkOutput("add r0 rfWE", 32'(a_rfWE), 32'd0);
        checkOutput("add r0 valid", 32'(a_valid), 32'd1);
        checkOutput("add r0 illegal", 32'(a_ill), 32'd0);

        applyStimulus(1'b1, 32'h00221820, 32'h200, 1'b0, 1'b0);
        checkOutput("stall in_ready", 32'(a_inRdy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("stall valid", 32'(a_valid), 32'd1);
            checkOutput("stall pc", a_pc, 32'h104);
            checkOutput("stall rs", 32'(a_rs), 32'd1);
            checkOutput("stall rfDst", 32'(a_dst), 32'd0);
            checkOutput("stall in_ready", 32'(a_inRdy), 32'd0);
            checkOutput("stall cnt_issued", 32'(a_cIss), 32'd10);
        end

        applyStimulus(1'b1, 32'h00221820, 32'h200, 1'b0, 1'b1);
        checkOutput("flush in_ready", 32'(a_inRdy), 32'd0);
        tick();
        checkOutput("flush out_valid", 32'(a_valid), 32'd0);
        checkOutput("flush cnt_issued", 32'(a_cIss), 32'd10);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("post flush out_valid", 32'(a_valid), 32'd0);
        checkOutput("post flush cnt_issued", 32'(a_cIss), 32'd10);

        applyStimulus(1'b1, 32'h00221820, 32'h300, 1'b1, 1'b0);
        tick();
        checkOutput("pre reset valid", 32'(a_valid), 32'd1);
        checkOutput("pre reset cnt_issued", 32'(a_cIss), 32'd11);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async reset valid", 32'(a_valid), 32'd0);
        checkOutput("async reset cnt_issued", 32'(a_cIss), 32'd0);
        checkOutput("async reset cnt_bubbles", 32'(a_cBub), 32'd0);
        checkOutput("async reset noext cnt_illegal", 32'(z_cIll), 32'd0);
        checkOutput("async reset small cnt_issued", 32'(c_cIss), 32'd0);
        checkOutput("async reset rfDst", 32'(a_dst), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
